// File: rtl/cc_frame_driver.sv
// Streams a two-channel half-buffer frame into a pair of FFT AXIS ports, preceded by one config beat per channel.
// Optional macro CC_SYNC_CHECK_EN enables the sticky x/y tready mismatch detector on sync_err.
module cc_frame_driver #(
  parameter int          SAMPLE_W       = 10,
  parameter int          N_FFT          = 256,
  parameter logic [15:0] SCALE_SCHEDULE = 16'b01_01_01_01_01_01_01_10,
  parameter int          FWD            = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [$clog2(N_FFT/2)-1:0]      wr_addr,
  input  logic [SAMPLE_W-1:0]             wr_x,
  input  logic [SAMPLE_W-1:0]             wr_y,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            x_cfg_tvalid,
  output logic                            y_cfg_tvalid,
  input  logic                            x_cfg_tready,
  input  logic                            y_cfg_tready,
  output logic [23:0]                     cfg_tdata,
  output logic [31:0]                     x_tdata,
  output logic [31:0]                     y_tdata,
  output logic                            x_tvalid,
  output logic                            y_tvalid,
  input  logic                            x_tready,
  input  logic                            y_tready,
  output logic                            x_tlast,
  output logic                            y_tlast,
  output logic                            sync_err
);

  localparam int HALF = N_FFT / 2;
  localparam int AW   = $clog2(HALF);
  localparam int KW   = $clog2(N_FFT);

  typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_STREAM, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic                x_cfg_tvalid_q, x_cfg_tvalid_d;
  logic                y_cfg_tvalid_q, y_cfg_tvalid_d;
  logic                x_tvalid_q, x_tvalid_d;
  logic                y_tvalid_q, y_tvalid_d;
  logic                tlast_q, tlast_d;
  logic [15:0]         x_re_q, x_re_d;
  logic [15:0]         y_re_q, y_re_d;

  logic [SAMPLE_W-1:0] xbuf [HALF];
  logic [SAMPLE_W-1:0] ybuf [HALF];
  logic [SAMPLE_W-1:0] x_rd_q, y_rd_q;
  logic [AW-1:0]       rd_addr;

  logic                cfg_done, beat_done, last_k, load;
  logic [KW-1:0]       ld_idx;

  assign cfg_done  = (!x_cfg_tvalid_q || x_cfg_tready) && (!y_cfg_tvalid_q || y_cfg_tready);
  assign beat_done = (!x_tvalid_q || x_tready) && (!y_tvalid_q || y_tready);
  assign last_k    = (k_q == KW'(N_FFT - 1));
  assign load      = ((state_q == S_CONFIG) && cfg_done) ||
                     ((state_q == S_STREAM) && beat_done && !last_k);
  // Index of the sample that the next load presents; its buffer word is already in x_rd_q/y_rd_q.
  assign ld_idx    = (state_q == S_STREAM) ? k_q + KW'(1) : '0;

  // Buffers are never reset; the read address looks one sample ahead so a new beat can load every cycle.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && wr_en) begin
      xbuf[wr_addr] <= wr_x;
      ybuf[wr_addr] <= wr_y;
    end
    x_rd_q <= xbuf[rd_addr];
    y_rd_q <= ybuf[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      k_q            <= '0;
      x_cfg_tvalid_q <= 1'b0;
      y_cfg_tvalid_q <= 1'b0;
      x_tvalid_q     <= 1'b0;
      y_tvalid_q     <= 1'b0;
      tlast_q        <= 1'b0;
      x_re_q         <= '0;
      y_re_q         <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      x_cfg_tvalid_q <= x_cfg_tvalid_d;
      y_cfg_tvalid_q <= y_cfg_tvalid_d;
      x_tvalid_q     <= x_tvalid_d;
      y_tvalid_q     <= y_tvalid_d;
      tlast_q        <= tlast_d;
      x_re_q         <= x_re_d;
      y_re_q         <= y_re_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CONFIG;
      S_CONFIG: if (cfg_done) state_d = S_STREAM;
      S_STREAM: if (beat_done && last_k) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_cfg_tvalid_d = x_cfg_tvalid_q && !x_cfg_tready;
    y_cfg_tvalid_d = y_cfg_tvalid_q && !y_cfg_tready;
    x_tvalid_d     = x_tvalid_q && !x_tready;
    y_tvalid_d     = y_tvalid_q && !y_tready;
    tlast_d        = tlast_q;
    x_re_d         = x_re_q;
    y_re_d         = y_re_q;
    k_d            = k_q;
    if (state_q == S_IDLE && start) begin
      x_cfg_tvalid_d = 1'b1;
      y_cfg_tvalid_d = 1'b1;
    end
    if (load) begin
      x_tvalid_d = 1'b1;
      y_tvalid_d = 1'b1;
      k_d        = ld_idx;
      tlast_d    = (ld_idx == KW'(N_FFT - 1));
      // Upper half of the frame carries x, lower half carries y.
      x_re_d     = ld_idx[KW-1] ? 16'($signed(x_rd_q)) : 16'h0000;
      y_re_d     = ld_idx[KW-1] ? 16'h0000 : 16'($signed(y_rd_q));
    end
    if (state_q == S_STREAM && beat_done && last_k) begin
      tlast_d = 1'b0;
      k_d     = '0;
    end
    rd_addr = (state_d == S_STREAM) ? AW'(k_d + KW'(1)) : '0;
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign x_cfg_tvalid = x_cfg_tvalid_q;
  assign y_cfg_tvalid = y_cfg_tvalid_q;
  assign cfg_tdata    = {7'b0, SCALE_SCHEDULE, 1'(FWD)};
  assign x_tvalid     = x_tvalid_q;
  assign y_tvalid     = y_tvalid_q;
  assign x_tlast      = tlast_q;
  assign y_tlast      = tlast_q;
  assign x_tdata      = {16'h0000, x_re_q};
  assign y_tdata      = {16'h0000, y_re_q};

`ifdef CC_SYNC_CHECK_EN
  logic sync_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_err_q <= 1'b0;
    end else if (state_q == S_STREAM && x_tvalid_q && y_tvalid_q && (x_tready != y_tready)) begin
      sync_err_q <= 1'b1;
    end
  end

  assign sync_err = sync_err_q;
`else
  assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_cc_frame_driver.sv
// Directed bench for cc_frame_driver: a frame-level model predicts every beat; a negedge monitor checks each cycle.
module tb_cc_frame_driver;
  localparam int N = 256;
  localparam int H = 128;
`ifdef CC_SYNC_CHECK_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [9:0]  wr_x = '0, wr_y = '0;
  logic        busy, done, x_cfg_tvalid, y_cfg_tvalid;
  logic        x_cfg_tready = 1'b1, y_cfg_tready = 1'b1;
  logic [23:0] cfg_tdata;
  logic [31:0] x_tdata, y_tdata;
  logic        x_tvalid, y_tvalid, x_tlast, y_tlast, sync_err;
  logic        x_tready = 1'b1, y_tready = 1'b1;
  bit          rnd_mode = 1'b0;

  cc_frame_driver dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
    .start(start), .busy(busy), .done(done),
    .x_cfg_tvalid(x_cfg_tvalid), .y_cfg_tvalid(y_cfg_tvalid),
    .x_cfg_tready(x_cfg_tready), .y_cfg_tready(y_cfg_tready), .cfg_tdata(cfg_tdata),
    .x_tdata(x_tdata), .y_tdata(y_tdata), .x_tvalid(x_tvalid), .y_tvalid(y_tvalid),
    .x_tready(x_tready), .y_tready(y_tready), .x_tlast(x_tlast), .y_tlast(y_tlast),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Frame model: buffer contents plus the beat mapping rules.
  logic [9:0] mx [H];
  logic [9:0] my [H];

  function automatic logic [31:0] real_word(input logic [9:0] v);
    int s;
    s = int'(v);
    if (v[9]) s = s - 1024;
    return {16'h0000, 16'(s)};
  endfunction

  function automatic logic [31:0] exp_x(input int k);
    return (k < H) ? 32'h0 : real_word(mx[k-H]);
  endfunction

  function automatic logic [31:0] exp_y(input int k);
    return (k < H) ? real_word(my[k]) : 32'h0;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rnd_mode) begin
      x_tready = 1'($urandom_range(0, 1));
      y_tready = 1'($urandom_range(0, 1));
    end else begin
      x_tready = 1'b1;
      y_tready = 1'b1;
    end
  end

  // Monitor
  int          xc = 0, yc = 0, cyc = 0, first_cyc = 0, last_hs_cyc = 0, done_cyc = 0, n_done = 0;
  logic [31:0] xcap [N];
  logic [31:0] ycap [N];
  bit          xs_prev = 0, ys_prev = 0, exp_sync = 0;
  logic [31:0] xd_prev, yd_prev;
  logic        xl_prev, yl_prev;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      xc = 0; yc = 0; xs_prev = 0; ys_prev = 0; exp_sync = 0;
    end else begin
      chk("sync_err", sync_err, exp_sync);
      if (SYNC_EN && x_tvalid && y_tvalid && (x_tready != y_tready)) exp_sync = 1'b1;
      if (start && !busy) begin
        xc = 0; yc = 0;
      end
      if (xs_prev) begin
        chk("x_hold_valid", x_tvalid, 1);
        chk("x_hold_data", x_tdata, xd_prev);
        chk("x_hold_last", x_tlast, xl_prev);
      end
      if (ys_prev) begin
        chk("y_hold_valid", y_tvalid, 1);
        chk("y_hold_data", y_tdata, yd_prev);
        chk("y_hold_last", y_tlast, yl_prev);
      end
      if (x_tvalid && x_tready) begin
        chk("x_beat_in_frame", xc < N, 1);
        if (xc < N) begin
          chk("x_beat_data", x_tdata, exp_x(xc));
          chk("x_beat_last", x_tlast, xc == N-1);
          xcap[xc] = x_tdata;
          if (xc == 0) first_cyc = cyc;
        end
        last_hs_cyc = cyc;
        xc++;
      end
      if (y_tvalid && y_tready) begin
        chk("y_beat_in_frame", yc < N, 1);
        if (yc < N) begin
          chk("y_beat_data", y_tdata, exp_y(yc));
          chk("y_beat_last", y_tlast, yc == N-1);
          ycap[yc] = y_tdata;
        end
        last_hs_cyc = cyc;
        yc++;
      end
      xs_prev = x_tvalid && !x_tready; xd_prev = x_tdata; xl_prev = x_tlast;
      ys_prev = y_tvalid && !y_tready; yd_prev = y_tdata; yl_prev = y_tlast;
      if (done) begin
        chk("done_x_beats", xc, N);
        chk("done_y_beats", yc, N);
        chk("done_latency", cyc - last_hs_cyc, 1);
        done_cyc = cyc;
        n_done++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({name, "_done_seen"}, i < 5000, 1);
    $display("[TB] frame %s: x beats %0d, y beats %0d, sync_err %0b", name, xc, yc, sync_err);
    tick();
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_cfg_valids"}, {x_cfg_tvalid, y_cfg_tvalid}, 0);
    chk({name, "_tvalids"}, {x_tvalid, y_tvalid}, 0);
    chk({name, "_tlasts"}, {x_tlast, y_tlast}, 0);
    chk({name, "_x_tdata"}, x_tdata, 0);
    chk({name, "_y_tdata"}, y_tdata, 0);
    chk({name, "_sync_err"}, sync_err, 0);
  endtask

  initial begin
    int nd;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset_state");
    tick();
    reset = 1'b0;
    tick();
    chk("cfg_tdata", cfg_tdata, 24'h00AAAD);

    for (int i = 0; i < H; i++) begin
      wr_en = 1'b1; wr_addr = 7'(i); wr_x = 10'(i); wr_y = 10'(10'h3FF - i);
      mx[i] = 10'(i); my[i] = 10'(10'h3FF - i);
      tick();
    end
    wr_en = 1'b0;

    // Full-throughput frame with latency checks
    pulse_start();
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_cfg_valids", {x_cfg_tvalid, y_cfg_tvalid}, 2'b11);
    chk("start_no_data_yet", x_tvalid, 0);
    tick();
    @(negedge clk);
    chk("first_beat_valids", {x_tvalid, y_tvalid}, 2'b11);
    chk("first_beat_cfg_dropped", {x_cfg_tvalid, y_cfg_tvalid}, 2'b00);
    chk("first_beat_x", x_tdata, 32'h0);
    chk("first_beat_y", y_tdata, 32'h0000FFFF);
    wait_done("fill");
    chk("fill_x0", xcap[0], 32'h0);
    chk("fill_x128", xcap[128], 32'h0);
    chk("fill_x255", xcap[255], 32'h0000007F);
    chk("fill_y0", ycap[0], 32'h0000FFFF);
    chk("fill_y127", ycap[127], 32'h0000FF80);
    chk("fill_y128", ycap[128], 32'h0);
    chk("fill_consecutive", done_cyc - first_cyc, N);
    chk("fill_idle_after", busy, 0);

    // Negative full-scale sample
    wr_en = 1'b1; wr_addr = 7'd0; wr_x = 10'h200; wr_y = 10'h3FF;
    mx[0] = 10'h200;
    tick();
    wr_en = 1'b0;
    pulse_start();
    wait_done("negative");
    chk("neg_x128", xcap[128], 32'h0000FE00);

    // y config backpressure for five cycles
    y_cfg_tready = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("cfgbp_x_cfg_valid", x_cfg_tvalid, i == 0);
      chk("cfgbp_y_cfg_valid", y_cfg_tvalid, 1);
      chk("cfgbp_no_stream", x_tvalid | y_tvalid, 0);
      tick();
    end
    y_cfg_tready = 1'b1;
    @(negedge clk);
    chk("cfgbp_still_config", x_tvalid, 0);
    tick();
    @(negedge clk);
    chk("cfgbp_stream_valids", {x_tvalid, y_tvalid}, 2'b11);
    chk("cfgbp_y_cfg_dropped", y_cfg_tvalid, 0);
    wait_done("cfg_backpressure");

    // Independent random backpressure
    rnd_mode = 1'b1;
    pulse_start();
    wait_done("random");
    rnd_mode = 1'b0;
    chk("random_sync_err", sync_err, SYNC_EN);

    // Reset mid-frame
    pulse_start();
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (xc >= 100) break;
    end
    chk("midreset_reached_100", xc >= 100, 1);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    tick();
    reset = 1'b0;
    tick();
    pulse_start();
    wait_done("after_reset");

    // start and wr_en during STREAM are ignored
    nd = n_done;
    pulse_start();
    repeat (4) tick();
    start = 1'b1; wr_en = 1'b1; wr_addr = 7'd5; wr_x = 10'h155; wr_y = 10'h0AA;
    tick();
    start = 1'b0; wr_en = 1'b0;
    wait_done("ignore_inputs");
    repeat (3) tick();
    chk("ignore_one_done", n_done - nd, 1);
    chk("ignore_stays_idle", busy, 0);
    pulse_start();
    wait_done("buffer_kept");
    chk("kept_x133", xcap[133], 32'h00000005);
    chk("kept_y5", ycap[5], 32'h0000FFFA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
